// File: rtl/bsg_wormhole_link_scheduler_pkg.sv
// Shared types for the wormhole link scheduler: header layout macro, FSM states and
// a circular index helper.
`ifndef BSG_WORMHOLE_LINK_SCHEDULER_PKG_SV
`define BSG_WORMHOLE_LINK_SCHEDULER_PKG_SV

`define DECLARE_BSG_WORMHOLE_HEADER_S(width_mp, cord_width_mp, len_width_mp, struct_name_mp) \
    typedef struct packed { \
        logic [(width_mp)-(cord_width_mp)-(len_width_mp)-1:0] payload; \
        logic [(len_width_mp)-1:0] len; \
        logic [(cord_width_mp)-1:0] cord; \
    } struct_name_mp

package bsg_wormhole_link_scheduler_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StLock = 1'b1
    } state_e;

    // Next index in a ring of num entries, wrapping num-1 -> 0.
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned num);
        return (idx + 1 == num) ? 0 : idx + 1;
    endfunction

endpackage

`endif

// File: rtl/bsg_wormhole_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start_i.
module bsg_wormhole_rr_pick
    import bsg_wormhole_link_scheduler_pkg::*;
#(
    parameter int unsigned num_p   = 4,
    parameter int unsigned idx_w_p = 2
) (
    input  logic [num_p-1:0]   reqs_i,
    input  logic [idx_w_p-1:0] start_i,
    output logic [num_p-1:0]   grant_o,
    output logic [idx_w_p-1:0] idx_o,
    output logic               found_o
);

    logic [idx_w_p-1:0] scan;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_o = 1'b0;
        scan    = start_i;
        for (int unsigned k = 0; k < num_p; k++) begin
            if (!found_o && reqs_i[scan]) begin
                found_o       = 1'b1;
                idx_o         = scan;
                grant_o[scan] = 1'b1;
            end
            scan = idx_w_p'(next_index(32'(scan), num_p));
        end
    end

endmodule

// File: rtl/bsg_wormhole_link_scheduler.sv
// Packet-granular arbiter sharing one downstream wormhole link among num_in_p sources,
// with an optional multi-packet quantum per grant.
module bsg_wormhole_link_scheduler
    import bsg_wormhole_link_scheduler_pkg::*;
#(
    parameter int unsigned width_p      = 64,
    parameter int unsigned num_in_p     = 4,
    parameter int unsigned cord_width_p = 7,
    parameter int unsigned len_width_p  = 4,
    parameter int unsigned quantum_p    = 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_in_p-1:0]                valid_i,
    input  logic [num_in_p-1:0][width_p-1:0]   data_i,
    output logic [num_in_p-1:0]                ready_and_o,
    output logic                               valid_o,
    output logic [width_p-1:0]                 data_o,
    input  logic                               ready_and_i,
    output logic [num_in_p-1:0]                grant_o,
    output logic                               busy_o
);

    localparam int unsigned idx_w = $clog2(num_in_p);
    localparam int unsigned cnt_w = $clog2(quantum_p + 1);

    `DECLARE_BSG_WORMHOLE_HEADER_S(width_p, cord_width_p, len_width_p, header_s);

    state_e                 state_r;
    logic [idx_w-1:0]       owner_r;
    logic [cnt_w-1:0]       pkt_cnt_r;
    logic [len_width_p-1:0] flits_left_r;

    logic [idx_w-1:0]    start_idx, pick_idx, winner, sel;
    logic [num_in_p-1:0] pick_grant, gnt;
    logic                pick_found, quantum_hold, any_valid, handshake;
    logic [cnt_w-1:0]    cnt_eff, cnt_base, cnt_inc, cnt_next;
    header_s             hdr;
    logic                unused_hdr_fields;

    assign start_idx = idx_w'(next_index(32'(owner_r), num_in_p));

    bsg_wormhole_rr_pick #(
        .num_p  (num_in_p),
        .idx_w_p(idx_w)
    ) u_pick (
        .reqs_i (valid_i),
        .start_i(start_idx),
        .grant_o(pick_grant),
        .idx_o  (pick_idx),
        .found_o(pick_found)
    );

    // Quantum continues only while the previous owner still has a header waiting.
    assign quantum_hold = (pkt_cnt_r != '0) && valid_i[owner_r];
    assign winner       = quantum_hold ? owner_r : pick_idx;
    assign any_valid    = quantum_hold || pick_found;
    assign cnt_eff      = quantum_hold ? pkt_cnt_r : '0;
    assign sel          = (state_r == StLock) ? owner_r : winner;

    assign hdr               = data_i[winner];
    assign unused_hdr_fields = ^{hdr.payload, hdr.cord};

    always_comb begin
        gnt         = '0;
        grant_o     = '0;
        ready_and_o = '0;
        valid_o     = 1'b0;
        data_o      = '0;
        if (reset_n_i && (state_r == StLock || any_valid)) begin
            if (state_r == StLock || quantum_hold) begin
                gnt[sel] = 1'b1;
            end else begin
                gnt = pick_grant;
            end
            grant_o     = gnt;
            valid_o     = valid_i[sel];
            data_o      = data_i[sel];
            ready_and_o = gnt & {num_in_p{ready_and_i}};
        end
    end

    assign handshake = valid_o && ready_and_i;
    assign cnt_base  = (state_r == StIdle) ? cnt_eff : pkt_cnt_r;
    assign cnt_inc   = cnt_base + 1'b1;
    assign cnt_next  = (cnt_inc == cnt_w'(quantum_p)) ? '0 : cnt_inc;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= StIdle;
            owner_r      <= idx_w'(num_in_p - 1);
            pkt_cnt_r    <= '0;
            flits_left_r <= '0;
            busy_o       <= 1'b0;
        end else if (handshake) begin
            unique case (state_r)
                StIdle: begin
                    owner_r <= winner;
                    if (hdr.len == '0) begin
                        pkt_cnt_r <= cnt_next;
                    end else begin
                        pkt_cnt_r    <= cnt_eff;
                        flits_left_r <= hdr.len;
                        state_r      <= StLock;
                        busy_o       <= 1'b1;
                    end
                end
                StLock: begin
                    flits_left_r <= flits_left_r - 1'b1;
                    if (flits_left_r == len_width_p'(1)) begin
                        pkt_cnt_r <= cnt_next;
                        state_r   <= StIdle;
                        busy_o    <= 1'b0;
                    end
                end
                default: state_r <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_wormhole_link_scheduler.sv
// Randomized and directed bench for the wormhole link scheduler against a packet-level model.
module tb_bsg_wormhole_link_scheduler;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int CW = 7;
    localparam int LW = 4;
    localparam int Q  = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N-1:0]        valid_i;
    logic [N-1:0][W-1:0] data_i;
    logic [N-1:0]        ready_and_o;
    logic                valid_o;
    logic [W-1:0]        data_o;
    logic                ready_and_i;
    logic [N-1:0]        grant_o;
    logic                busy_o;

    bsg_wormhole_link_scheduler #(
        .width_p     (W),
        .num_in_p    (N),
        .cord_width_p(CW),
        .len_width_p (LW),
        .quantum_p   (Q)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .ready_and_o(ready_and_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_and_i(ready_and_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Upstream packet sources.
    bit src_en[N];
    bit src_hdr[N];
    int src_body[N];
    int src_plen[N];
    int src_budget[N];
    int src_lfix[N];
    int len_max = 5;
    int p_valid = 100;
    int p_ready = 100;
    int ready_q[$];
    logic [N-1:0] hs_src;

    // Packet-level model of the link: who owns it, flits left, packets in the current run.
    bit m_lock;
    int m_owner;
    int m_left;
    int m_cnt;

    logic [N-1:0] e_grant, e_rdy;
    logic         e_valid;
    logic [W-1:0] e_data;
    int           e_win, e_cnt;

    int dut_log[$], dut_logc[$], mdl_log[$];
    logic [W-1:0] dq[$];
    int cnt_busy, cnt_flit2;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] g);
        int r = -1;
        for (int k = N - 1; k >= 0; k--) if (g[k]) r = k;
        return r;
    endfunction

    function automatic int bump(input int c);
        return (c + 1 == Q) ? 0 : c + 1;
    endfunction

    task automatic model_eval();
        e_grant = '0; e_rdy = '0; e_valid = 1'b0; e_data = '0; e_win = -1; e_cnt = m_cnt;
        if (reset_n) begin
            if (m_lock) begin
                e_win = m_owner;
            end else if (m_cnt != 0 && valid_i[m_owner]) begin
                e_win = m_owner;
            end else begin
                e_cnt = 0;
                for (int k = 1; k <= N; k++) begin
                    if (e_win < 0 && valid_i[(m_owner + k) % N]) e_win = (m_owner + k) % N;
                end
            end
            if (e_win >= 0) begin
                e_grant[e_win] = 1'b1;
                e_valid        = valid_i[e_win];
                e_data         = data_i[e_win];
                e_rdy[e_win]   = ready_and_i;
            end
        end
    endtask

    task automatic model_update();
        logic [W-1:0] d;
        int len;
        if (reset_n && e_valid && ready_and_i) begin
            if (!m_lock) begin
                d = e_data;
                len = int'(d[CW +: LW]);
                m_owner = e_win;
                mdl_log.push_back(e_win);
                m_cnt = e_cnt;
                if (len == 0) m_cnt = bump(m_cnt);
                else begin
                    m_lock = 1'b1;
                    m_left = len;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_lock = 1'b0;
                    m_cnt  = bump(m_cnt);
                end
            end
        end
    endtask

    task automatic drive();
        logic [W-1:0] f;
        for (int i = 0; i < N; i++) begin
            if (hs_src[i] || !valid_i[i]) begin
                valid_i[i] = 1'b0;
                if (src_en[i] && src_budget[i] > 0 && $urandom_range(99) < p_valid) begin
                    valid_i[i] = 1'b1;
                    f = {$urandom, $urandom};
                    if (src_body[i] == 0) begin
                        src_hdr[i]  = 1'b1;
                        src_plen[i] = (src_lfix[i] >= 0) ? src_lfix[i] : $urandom_range(len_max);
                        f[CW +: LW] = LW'(src_plen[i]);
                    end else begin
                        src_hdr[i] = 1'b0;
                    end
                    data_i[i] = f;
                end
            end
        end
        if (ready_q.size() > 0) ready_and_i = (ready_q.pop_front() != 0);
        else ready_and_i = ($urandom_range(99) < p_ready);
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        model_eval();
        chk("grant", grant_o, e_grant);
        chk("valid", valid_o, e_valid);
        chk("data", data_o, e_data);
        chk("ready_and", ready_and_o, e_rdy);
        chk("busy", busy_o, m_lock);
        if (reset_n && valid_o && ready_and_i && !busy_o) begin
            dut_log.push_back(oh2i(grant_o));
            dut_logc.push_back(cyc);
        end
        if (busy_o) cnt_busy++;
        if (valid_o && ready_and_i && grant_o == 4'b0100) cnt_flit2++;
        dq.push_back(data_o);
        @(posedge clk);
        model_update();
        hs_src = valid_i & e_rdy;
        for (int i = 0; i < N; i++) begin
            if (hs_src[i]) begin
                if (src_hdr[i]) src_body[i] = src_plen[i];
                else src_body[i]--;
                if (src_body[i] == 0) src_budget[i]--;
            end
        end
        #1;
        drive();
    endtask

    task automatic clear_logs();
        dut_log.delete(); dut_logc.delete(); mdl_log.delete(); dq.delete();
        cnt_busy = 0; cnt_flit2 = 0;
    endtask

    // Reset is asserted between clock edges; outputs must drop immediately.
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_grant", grant_o, '0);
        chk("rst_valid", valid_o, '0);
        chk("rst_data", data_o, '0);
        chk("rst_ready", ready_and_o, '0);
        chk("rst_busy", busy_o, '0);
        m_lock = 1'b0; m_owner = N - 1; m_left = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            src_body[i] = 0;
            src_hdr[i]  = 1'b0;
        end
        valid_i = '0;
        hs_src  = '0;
        ready_q.delete();
        repeat (ncyc) cycle();
        reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic cfg(input logic [N-1:0] en, input int budget, input int lfix);
        for (int i = 0; i < N; i++) begin
            src_en[i]     = en[i];
            src_budget[i] = budget;
            src_lfix[i]   = lfix;
        end
    endtask

    task automatic check_log(input string nm, input int exp[$]);
        chk({nm, "_count"}, dut_log.size(), exp.size());
        chk({nm, "_model_count"}, mdl_log.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            if (k < dut_log.size()) chk({nm, "_order"}, dut_log[k], exp[k]);
            if (k < mdl_log.size()) chk({nm, "_model_order"}, mdl_log[k], exp[k]);
        end
    endtask

    int exp_q[$];

    initial begin
        reset_n = 1'b0;
        valid_i = '0;
        data_i = '0;
        ready_and_i = 1'b0;
        hs_src = '0;
        p_valid = 100;
        p_ready = 100;

        // Single source, len=3.
        cfg(4'b0100, 1, 3);
        do_reset(2);
        repeat (8) cycle();
        chk("single_flits", cnt_flit2, 4);
        chk("single_busy", cnt_busy, 3);
        exp_q = '{2};
        check_log("single", exp_q);

        // Quantum run on two always-valid sources with len=0 packets.
        cfg(4'b0011, 100, 0);
        do_reset(2);
        repeat (7) cycle();
        exp_q = '{0, 0, 0, 1, 1, 1, 0};
        check_log("quantum", exp_q);

        // Owner drops after one packet: next source starts a fresh quantum at once.
        cfg(4'b0111, 100, 0);
        src_budget[0] = 1;
        do_reset(2);
        repeat (5) cycle();
        exp_q = '{0, 1, 1, 1, 2};
        check_log("qdrop", exp_q);
        if (dut_logc.size() >= 2) chk("qdrop_gap", dut_logc[1] - dut_logc[0], 1);

        // Lock hold: input 1 waits for input 0's len=5 packet.
        cfg(4'b0011, 1, 0);
        src_lfix[0] = 5;
        do_reset(2);
        repeat (8) cycle();
        exp_q = '{0, 1};
        check_log("lock", exp_q);
        if (dut_logc.size() >= 2) chk("lock_gap", dut_logc[1] - dut_logc[0], 6);

        // Backpressure during a body.
        cfg(4'b0100, 1, 3);
        do_reset(2);
        ready_q = '{1, 0, 0, 1, 1};
        repeat (8) cycle();
        chk("bp_busy", cnt_busy, 5);
        exp_q = '{2};
        check_log("bp", exp_q);
        if (dq.size() >= 5) begin
            chk("bp_stall1", dq[3], dq[2]);
            chk("bp_stall2", dq[4], dq[2]);
        end

        // Async reset in mid-packet.
        cfg(4'b1111, 1000, 4);
        do_reset(2);
        repeat (3) cycle();
        chk("pre_rst_busy", busy_o, 1'b1);
        do_reset(2);
        repeat (1) cycle();
        exp_q = '{0};
        check_log("post_rst", exp_q);

        // Randomized traffic.
        cfg(4'b1111, 1000000, -1);
        len_max = 5;
        p_valid = 60;
        p_ready = 70;
        do_reset(2);
        repeat (1500) cycle();
        do_reset(3);
        repeat (1500) cycle();
        p_valid = 100;
        p_ready = 100;
        repeat (500) cycle();
        p_valid = 30;
        p_ready = 40;
        repeat (500) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
